// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// Build option: SAR_EARLY_EXIT_EN (see sar_search).
package sar_pkg;

    localparam int SAR_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } sar_state_e;

    // A trustworthy comparator asserts exactly one of eq/lt/gt.
    function automatic logic sar_flags_onehot(input logic eq, input logic lt, input logic gt);
        return $onehot({eq, lt, gt});
    endfunction

endpackage

// File: rtl/sar_step.sv
// One successive-approximation decision: next accumulator, next bit index,
// last-bit and flag-error indications from the current comparator result.
module sar_step
    import sar_pkg::*;
#(
    parameter int W  = SAR_W_DEFAULT,
    parameter int KW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  acc,
    input  logic [KW-1:0] k,
    input  logic          cmp_eq,
    input  logic          cmp_lt,
    input  logic          cmp_gt,
    output logic [W-1:0]  acc_next,
    output logic [KW-1:0] k_next,
    output logic          last,
    output logic          error
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        // Probe above target clears the trial bit; lt or eq keeps it.
        acc_next = cmp_gt ? acc : (acc | (ONE << k));
        k_next   = k - KW'(1);
        last     = (k == '0);
        error    = !sar_flags_onehot(cmp_eq, cmp_lt, cmp_gt);
    end

endmodule

// File: rtl/sar_search.sv
// Sequential SAR search: probes an external comparator MSB first and recovers the target.
// Build option: define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports equality.
module sar_search
    import sar_pkg::*;
#(
    parameter int W = SAR_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_eq,
    input  logic         cmp_lt,
    input  logic         cmp_gt,
    output logic [W-1:0] probe,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         found,
    output logic         err
);

    localparam int KW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] PROBE = 2'(ST_PROBE);
    localparam logic [1:0] DONE  = 2'(ST_DONE);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MSB = ONE << (W - 1);

    logic [1:0]    state;
    logic [W-1:0]  acc;
    logic [KW-1:0] k;

    logic [W-1:0]  acc_next;
    logic [KW-1:0] k_next;
    logic          last;
    logic          error;

    sar_step #(.W(W), .KW(KW)) u_step (
        .acc      (acc),
        .k        (k),
        .cmp_eq   (cmp_eq),
        .cmp_lt   (cmp_lt),
        .cmp_gt   (cmp_gt),
        .acc_next (acc_next),
        .k_next   (k_next),
        .last     (last),
        .error    (error)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            k      <= '0;
            probe  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= PROBE;
                        acc   <= '0;
                        k     <= KW'(W - 1);
                        found <= 1'b0;
                        err   <= 1'b0;
                        probe <= MSB;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        probe <= '0;
                        busy  <= 1'b0;
                    end
                end
                PROBE: begin
                    // start is deliberately not examined here: a running search is never restarted.
                    if (error) begin
                        state  <= DONE;
                        err    <= 1'b1;
                        found  <= 1'b0;
                        result <= '0;
                        probe  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`ifdef SAR_EARLY_EXIT_EN
                    else if (cmp_eq) begin
                        state  <= DONE;
                        result <= probe;
                        found  <= 1'b1;
                        probe  <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
`endif
                    else begin
                        if (cmp_eq)
                            found <= 1'b1;
                        acc <= acc_next;
                        if (last) begin
                            state  <= DONE;
                            result <= acc_next;
                            probe  <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            k     <= k_next;
                            probe <= acc_next | (ONE << k_next);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    probe <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search with a behavioural comparator and an arithmetic reference model.
// Works with or without SAR_EARLY_EXIT_EN defined.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] target = '0;
    logic         ovr = 1'b0;
    logic         cmp_eq, cmp_lt, cmp_gt;
    logic [W-1:0] probe, result;
    logic         busy, done, found, err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    // Behavioural comparator; ovr forces an illegal lt+gt pattern.
    assign cmp_eq = ovr ? 1'b0 : (probe == target);
    assign cmp_lt = ovr ? 1'b1 : (probe <  target);
    assign cmp_gt = ovr ? 1'b1 : (probe >  target);

    sar_search #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_eq (cmp_eq),
        .cmp_lt (cmp_lt),
        .cmp_gt (cmp_gt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Probe issued at step s (1-based): target bits above position k kept, bit k set.
    function automatic int ref_probe(input int tgt, input int s);
        int kk;
        kk = W - s;
        return ((tgt >> (kk + 1)) << (kk + 1)) | (1 << kk);
    endfunction

    // Number of probes the search issues for a clean target.
    function automatic int ref_nprobes(input int tgt);
`ifdef SAR_EARLY_EXIT_EN
        int tz;
        if (tgt == 0) return W;
        tz = 0;
        while (((tgt >> tz) & 1) == 0) tz++;
        return W - tz;
`else
        return W + (tgt - tgt);
`endif
    endfunction

    // One search. mid: pulse start while busy. chain: raise start in the DONE cycle.
    // bad_step: step whose sampling edge sees corrupted flags (0 = none).
    task automatic run(input int tgt, input bit mid, input bit chain, input int bad_step);
        int  np, exp_lat, i;
        bit  got_done;
        np = ref_nprobes(tgt);
        exp_lat = (bad_step > 0) ? bad_step + 1 : np + 1;
        if (!start) begin
            @(negedge clk);
            start = 1'b1;
        end
        target = W'(tgt);
        @(posedge clk);
        #1 start = 1'b0;
        got_done = 1'b0;
        i = 0;
        while (!got_done && i < 3 * W + 5) begin
            @(negedge clk);
            i++;
            if (i == 2) start = 1'b0;
            if (bad_step > 0 && i == bad_step + 1) ovr = 1'b0;
            if (done) begin
                got_done = 1'b1;
                check("latency", i, exp_lat);
                check("result", result, (bad_step > 0) ? 0 : tgt);
                check("found", found, (bad_step > 0) ? 0 : (tgt != 0));
                check("err", err, (bad_step > 0) ? 1 : 0);
                check("busy_in_done", busy, 0);
                check("probe_in_done", probe, 0);
                $display("search target=%0d result=%0d found=%0d err=%0d cycles=%0d mid=%0d chain=%0d",
                         tgt, result, found, err, i, mid, chain);
                if (chain) start = 1'b1;
            end else begin
                check("busy", busy, 1);
                if (i <= np) check("probe", probe, ref_probe(tgt, i));
                if (mid && i == 1) start = 1'b1;
                if (bad_step > 0 && i == bad_step) ovr = 1'b1;
            end
        end
        if (!got_done) begin
            check("done_timeout", 0, 1);
            start = 1'b0;
            ovr = 1'b0;
        end else if (!chain) begin
            @(negedge clk);
            check("done_pulse_width", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_probe", probe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_found", found, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases: 5, 8, 0, 15
        run(5, 0, 0, 0);
        run(8, 0, 0, 0);
        run(0, 0, 0, 0);
        run(15, 0, 0, 0);

        // Illegal flags on the 2nd probe, then a clean search
        run(5, 0, 0, 2);
        run(3, 0, 0, 0);

        // Sweep of all targets with random mid-search and DONE-cycle starts
        for (int t = 0; t < 16; t++)
            run(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        run(10, 1, 1, 0);
        run(6, 0, 0, 0);

        // Random targets, random error injection
        for (int n = 0; n < 20; n++) begin
            int tg, bs;
            tg = $urandom_range(0, 15);
            bs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ref_nprobes(tg)) : 0;
            run(tg, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bs);
        end
        run(1, 0, 0, 0);

        // Reset during the 3rd probe aborts asynchronously without done
        @(negedge clk);
        target = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_probe", probe, ref_probe(9, 3));
        rst = 1'b1;
        #1;
        check("arst_probe", probe, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_result", result, 0);
        check("arst_found", found, 0);
        check("arst_err", err, 0);
        $display("reset abort probe=%0d busy=%0d done=%0d", probe, busy, done);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_done", done, 0);
        run(9, 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sar_search.md
# sar_search

Sequential successive-approximation search engine, the consumer of an external magnitude comparator's eq/lt/gt outputs. It drives a probe value into the comparator against an unknown target and recovers the target from the returned relation flags. It resolves the target one bit per cycle, MSB first. It sits beside the comparator in datapaths that must recover a hidden value, such as ADC SAR loops, threshold calibration and address search.

## Interface
- W, default 4: width of probe, target and result.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new search; sampled on the clk edge.
- cmp_eq  input  1  external comparator: probe == target.
- cmp_lt  input  1  external comparator: probe < target.
- cmp_gt  input  1  external comparator: probe > target.
- probe  output  W  value presented to the comparator's a input; registered.
- busy  output  1  search in progress; flags are sampled on every edge while high.
- done  output  1  one-cycle pulse, result valid.
- result  output  W  recovered target; held until the next accepted start.
- found  output  1  cmp_eq was seen during the search; qualified by done, held with result.
- err  output  1  comparator flags were not one-hot; qualified by done, held with result.

## Operation
- States: IDLE, PROBE, DONE. Internal registers: acc (W bits) and bit index k (clog2(W) bits).
- IDLE:
  - probe = 0, busy = 0.
  - start = 1 → acc = 0, k = W-1, found/err cleared, go to PROBE.
- PROBE:
  - probe = acc | (1<<k), busy = 1.
  - Each edge samples the flags.
  - cmp_gt: acc unchanged (bit k = 0).
  - cmp_lt or cmp_eq: acc |= 1<<k.
  - cmp_eq also sets found.
  - k == 0 → result = next acc, go to DONE; otherwise k = k-1.
- Flags not exactly one-hot (none set or several set) at a sampling edge:
  - err = 1, found = 0, result = 0.
  - Go to DONE immediately.
- DONE:
  - done = 1, busy = 0, probe = 0.
  - Next state is IDLE. If start = 1 in this cycle, next state is PROBE with a new search.
- start while busy = 1 is ignored. The running search is not disturbed.
- Target 0 never matches a probe, because every probe has a bit set. It resolves as result = 0, found = 0, err = 0. This is legal.
- The comparator is combinational and external. The flags must reflect the current probe within the same cycle.

## Timing
- Reset, asynchronous:
  - State IDLE.
  - probe, result = 0.
  - busy, done, found, err = 0.
- Reset asserted mid-search aborts the search immediately. No done pulse is generated.
- start accepted at edge 0 → probe = 2^(W-1) and busy = 1 from edge 0.
- Sampling edges are 1..W. done is high for the one cycle after edge W.
- Latency from start to done is W+1 cycles. Back-to-back searches: start in the DONE cycle gives one search per W+1 cycles.
- Error abort: done is asserted the cycle after the offending edge. Latency is then at most W+1 cycles.

## Configuration
- SAR_EARLY_EXIT_EN defined:
  - cmp_eq at any sampling edge → result = current probe, found = 1, go to DONE.
  - Latency is variable, 2..W+1 cycles.
- Not defined:
  - Always W sampling edges. Fixed latency of W+1.
  - cmp_eq is treated as lt for acc update and still sets found.
- result is identical in both builds for every target.

## Structure
- Package sar_pkg holds:
  - the state enum typedef (IDLE/PROBE/DONE);
  - default W;
  - a function returning the one-hot validity of {cmp_eq, cmp_lt, cmp_gt}.
- One sub-module, sar_step, is natural. It is combinational and computes next acc, next k, a last-bit flag and an error flag from acc, k and the flags.
- The FSM and output registers stay in sar_search.

## Test plan
- W = 4, behavioral comparator, target 5, early exit off:
  - probes 8, 4, 6, 5 → result = 5, found = 1, err = 0;
  - done exactly 5 cycles after the start edge.
- Same stimulus with SAR_EARLY_EXIT_EN:
  - target 5 → done after probe 5 (4th probe), result = 5;
  - target 8 → done after 1st probe, result = 8.
- Targets 0 and 15:
  - 0 → probes 8, 4, 2, 1, result = 0, found = 0;
  - 15 → probes 8, 12, 14, 15, result = 15, found = 1.
- Force cmp_lt = cmp_gt = 1 on the 2nd probe → done the next cycle, err = 1, result = 0. Then a clean search of target 3 → result = 3, err = 0.
- Sweep all 16 targets, with start pulsed during busy and in the DONE cycle:
  - mid-search starts ignored;
  - DONE-cycle start restarts;
  - every result equals its target.
- Assert rst on the 3rd probe → all outputs 0 asynchronously, no done. The next search of target 9 → result = 9.
